// File: rtl/branch_pkg.sv
// Shared types and table-geometry defaults for the branch update scheduler,
// the branch predictor and the BTB.
package branch_pkg;

    localparam int BUPD_ADDR_WIDTH  = 32;
    localparam int BUPD_CACHE_LINES = 64;

    typedef struct packed {
        logic [BUPD_ADDR_WIDTH-1:0] pc;
        logic                       taken;
        logic [BUPD_ADDR_WIDTH-1:0] trgt;
    } bupd_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } bupd_state_t;

endpackage

// File: rtl/bupd_fifo.sv
// Circular FIFO of resolved-branch records with wrap-bit pointers.
// Build option BUPD_COALESCE_EN merges a push into the newest entry when the PCs match.
module bupd_fifo
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = BUPD_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [ADDR_WIDTH-1:0]     push_pc_i,
    input  logic                      push_taken_i,
    input  logic [ADDR_WIDTH-1:0]     push_trgt_i,
    input  logic                      pop_i,
    output logic                      merge_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [ADDR_WIDTH-1:0]     head_pc_o,
    output logic                      head_taken_o,
    output logic [ADDR_WIDTH-1:0]     head_trgt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]           wr_q, wr_d;
    logic [PW:0]           rd_q, rd_d;
    logic [PW:0]           count;
    logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
    logic                  taken_mem_q[DEPTH];
    logic [ADDR_WIDTH-1:0] trgt_mem_q [DEPTH];

    assign count   = wr_q - rd_q;
    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == (PW+1)'(DEPTH));

    assign head_pc_o    = pc_mem_q[rd_q[PW-1:0]];
    assign head_taken_o = taken_mem_q[rd_q[PW-1:0]];
    assign head_trgt_o  = trgt_mem_q[rd_q[PW-1:0]];

`ifdef BUPD_COALESCE_EN
    logic [PW-1:0] tail_idx;
    assign tail_idx = wr_q[PW-1:0] - PW'(1);
    // A lone entry that is leaving this cycle cannot absorb the push.
    assign merge_o  = !empty_o && (pc_mem_q[tail_idx] == push_pc_i)
                      && !(pop_i && count == PTR_ONE);
`else
    assign merge_o  = 1'b0;
`endif

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i && !merge_o) wr_d = wr_q + PTR_ONE;
        if (pop_i)              rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
`ifdef BUPD_COALESCE_EN
            if (merge_o) begin
                taken_mem_q[tail_idx] <= push_taken_i;
                trgt_mem_q[tail_idx]  <= push_trgt_i;
            end else
`endif
            begin
                pc_mem_q[wr_q[PW-1:0]]    <= push_pc_i;
                taken_mem_q[wr_q[PW-1:0]] <= push_taken_i;
                trgt_mem_q[wr_q[PW-1:0]]  <= push_trgt_i;
            end
        end
    end

endmodule

// File: rtl/branch_update_sched.sv
// Sole writer of the branch predictor and BTB: drains queued branch updates and runs the
// full-table invalidate sweep. Build option BUPD_COALESCE_EN enables same-PC coalescing.
module branch_update_sched
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUPD_ADDR_WIDTH,
    parameter int CACHE_LINES = BUPD_CACHE_LINES,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           upd_valid_i,
    output logic                           upd_ready_o,
    input  logic [ADDR_WIDTH-1:0]          upd_pc_i,
    input  logic                           upd_taken_i,
    input  logic [ADDR_WIDTH-1:0]          upd_trgt_i,
    input  logic                           stall_i,
    input  logic                           clear_req_i,
    output logic                           clear_busy_o,
    output logic                           bp_we_o,
    output logic [ADDR_WIDTH-1:0]          bp_pc_o,
    output logic                           bp_taken_o,
    output logic                           btb_we_o,
    output logic [ADDR_WIDTH-1:0]          btb_addr_o,
    output logic [ADDR_WIDTH-1:0]          btb_data_o,
    output logic                           inv_we_o,
    output logic [$clog2(CACHE_LINES)-1:0] inv_idx_o,
    output logic [$clog2(QUEUE_DEPTH):0]   count_o
);

    localparam int IW = $clog2(CACHE_LINES);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CACHE_LINES - 1);

    bupd_state_t           state_q;
    logic [IW-1:0]         inv_idx_q;
    logic                  push, pop, merge, empty, full, bp_we, drained;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] head_pc, head_trgt;
    logic                  head_taken;

    bupd_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_pc_i    (upd_pc_i),
        .push_taken_i (upd_taken_i),
        .push_trgt_i  (upd_trgt_i),
        .pop_i        (pop),
        .merge_o      (merge),
        .empty_o      (empty),
        .full_o       (full),
        .count_o      (count),
        .head_pc_o    (head_pc),
        .head_taken_o (head_taken),
        .head_trgt_o  (head_trgt)
    );

    assign upd_ready_o = (state_q != CLEAR) && (!full || merge);
    assign push        = upd_valid_i && upd_ready_o;
    assign bp_we       = (state_q == DRAIN) && !empty && !stall_i;
    assign pop         = bp_we;
    assign drained     = !push && (empty || (pop && count == CW'(1)));

    // Write data is forced to zero whenever its strobe is low.
    assign bp_we_o    = bp_we;
    assign bp_pc_o    = bp_we ? head_pc : '0;
    assign bp_taken_o = bp_we && head_taken;
    assign btb_we_o   = bp_we && head_taken;
    assign btb_addr_o = (bp_we && head_taken) ? head_pc : '0;
    assign btb_data_o = (bp_we && head_taken) ? head_trgt : '0;

    assign inv_we_o     = (state_q == CLEAR);
    assign clear_busy_o = (state_q == CLEAR);
    assign inv_idx_o    = inv_idx_q;
    assign count_o      = count;

    // inv_idx_q is held at zero outside the sweep, so entering CLEAR needs no reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            inv_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clear_req_i)        state_q <= CLEAR;
                    else if (push || !empty) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (clear_req_i)  state_q <= CLEAR;
                    else if (drained) state_q <= IDLE;
                end
                CLEAR: begin
                    if (inv_idx_q == LAST_IDX) begin
                        state_q   <= IDLE;
                        inv_idx_q <= '0;
                    end else begin
                        inv_idx_q <= inv_idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_update_sched.sv
// Directed bench for branch_update_sched with a queue-based reference model checked every cycle.
module tb_branch_update_sched;
    import branch_pkg::*;

    localparam int AW = 32;
    localparam int CL = 64;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          upd_valid_i = 1'b0;
    logic          upd_ready_o;
    logic [AW-1:0] upd_pc_i = '0;
    logic          upd_taken_i = 1'b0;
    logic [AW-1:0] upd_trgt_i = '0;
    logic          stall_i = 1'b0;
    logic          clear_req_i = 1'b0;
    logic          clear_busy_o;
    logic          bp_we_o;
    logic [AW-1:0] bp_pc_o;
    logic          bp_taken_o;
    logic          btb_we_o;
    logic [AW-1:0] btb_addr_o;
    logic [AW-1:0] btb_data_o;
    logic          inv_we_o;
    logic [5:0]    inv_idx_o;
    logic [2:0]    count_o;

    always #5 clk = ~clk;

    branch_update_sched #(
        .ADDR_WIDTH  (AW),
        .CACHE_LINES (CL),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid_i  (upd_valid_i),
        .upd_ready_o  (upd_ready_o),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_trgt_i   (upd_trgt_i),
        .stall_i      (stall_i),
        .clear_req_i  (clear_req_i),
        .clear_busy_o (clear_busy_o),
        .bp_we_o      (bp_we_o),
        .bp_pc_o      (bp_pc_o),
        .bp_taken_o   (bp_taken_o),
        .btb_we_o     (btb_we_o),
        .btb_addr_o   (btb_addr_o),
        .btb_data_o   (btb_data_o),
        .inv_we_o     (inv_we_o),
        .inv_idx_o    (inv_idx_o),
        .count_o      (count_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending records, whether the queue is being written out, sweep progress.
    bupd_rec_t mq[$];
    bit        m_draining = 1'b0;
    bit        m_sweeping = 1'b0;
    int        m_idx      = 0;

    function automatic bit exp_we();
        return m_draining && !m_sweeping && mq.size() > 0 && !stall_i;
    endfunction

    function automatic bit exp_merge();
`ifdef BUPD_COALESCE_EN
        if (mq.size() == 0) return 1'b0;
        if (mq[mq.size()-1].pc != upd_pc_i) return 1'b0;
        return !(exp_we() && mq.size() == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready();
        return !m_sweeping && (mq.size() < QD || exp_merge());
    endfunction

    bit        mdl_we, mdl_push, mdl_merge;
    int        mdl_left;
    bupd_rec_t mdl_rec;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_draining = 1'b0;
            m_sweeping = 1'b0;
            m_idx      = 0;
        end else begin
            mdl_we    = exp_we();
            mdl_merge = exp_merge();
            mdl_push  = upd_valid_i && exp_ready();
            mdl_left  = mq.size() - (mdl_we ? 1 : 0) + ((mdl_push && !mdl_merge) ? 1 : 0);
            if (m_sweeping) begin
                if (m_idx == CL - 1) begin
                    m_sweeping = 1'b0;
                    m_idx      = 0;
                end else begin
                    m_idx++;
                end
            end else if (clear_req_i) begin
                m_sweeping = 1'b1;
                m_draining = 1'b0;
                m_idx      = 0;
            end else if (!m_draining) begin
                m_draining = (mq.size() > 0) || mdl_push;
            end else begin
                m_draining = (mdl_left > 0);
            end
            if (mdl_we) void'(mq.pop_front());
            if (mdl_push) begin
                if (mdl_merge) begin
                    mdl_rec       = mq[mq.size()-1];
                    mdl_rec.taken = upd_taken_i;
                    mdl_rec.trgt  = upd_trgt_i;
                    mq[mq.size()-1] = mdl_rec;
                end else begin
                    mdl_rec.pc    = upd_pc_i;
                    mdl_rec.taken = upd_taken_i;
                    mdl_rec.trgt  = upd_trgt_i;
                    mq.push_back(mdl_rec);
                end
            end
        end
    end

    bupd_rec_t cmp_head;
    bit        cmp_we;

    always @(negedge clk) begin
        if (!rst) begin
            cmp_we   = exp_we();
            cmp_head = (mq.size() > 0) ? mq[0] : '0;
            check("ready",    upd_ready_o,  exp_ready());
            check("count",    count_o,      mq.size());
            check("bp_we",    bp_we_o,      cmp_we);
            check("bp_pc",    bp_pc_o,      cmp_we ? cmp_head.pc : '0);
            check("bp_taken", bp_taken_o,   cmp_we && cmp_head.taken);
            check("btb_we",   btb_we_o,     cmp_we && cmp_head.taken);
            check("btb_addr", btb_addr_o,   (cmp_we && cmp_head.taken) ? cmp_head.pc : '0);
            check("btb_data", btb_data_o,   (cmp_we && cmp_head.taken) ? cmp_head.trgt : '0);
            check("inv_we",   inv_we_o,     m_sweeping);
            check("inv_idx",  inv_idx_o,    m_sweeping ? m_idx : 0);
            check("busy",     clear_busy_o, m_sweeping);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] pc, input bit tk, input logic [AW-1:0] tg);
        upd_valid_i = v;
        upd_pc_i    = pc;
        upd_taken_i = tk;
        upd_trgt_i  = tg;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    bit got;

    initial begin
        // Reset state
        #1;
        check("rst_count",  count_o,      0);
        check("rst_bp_we",  bp_we_o,      0);
        check("rst_btb_we", btb_we_o,     0);
        check("rst_inv_we", inv_we_o,     0);
        check("rst_idx",    inv_idx_o,    0);
        check("rst_busy",   clear_busy_o, 0);
        check("rst_bp_pc",  bp_pc_o,      0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Taken branch: written to both tables the cycle after it is accepted
        drive(1, 32'h100, 1, 32'h200);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t1_bp_we",    bp_we_o,    1);
        check("t1_btb_we",   btb_we_o,   1);
        check("t1_btb_addr", btb_addr_o, 32'h100);
        check("t1_btb_data", btb_data_o, 32'h200);
        step();
        check("t1_count", count_o, 0);

        // Not-taken branch: predictor only
        drive(1, 32'h104, 0, 32'h999);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t2_bp_we",    bp_we_o,    1);
        check("t2_bp_taken", bp_taken_o, 0);
        check("t2_btb_we",   btb_we_o,   0);
        step();

        // Fill under stall, then drain in order across the pointer wrap
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 32'(4 * i), i[0], 32'h300 + 32'(i));
            step();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("t3_count", count_o,     4);
        check("t3_ready", upd_ready_o, 0);
        check("t3_bp_we", bp_we_o,     0);
        step();
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_drain_pc",  bp_pc_o,  32'h200 + 32'(4 * i));
            check("t3_drain_btb", btb_we_o, i[0]);
            step();
        end
        check("t3_empty", count_o, 0);

        // Sweep with two entries held, then they drain
        stall_i = 1'b1;
        drive(1, 32'h400, 1, 32'h4a0);
        step();
        drive(1, 32'h404, 1, 32'h4a4);
        step();
        drive(0, 0, 0, 0);
        clear_req_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        stall_i     = 1'b0;
        for (int i = 0; i < CL; i++) begin
            @(negedge clk);
            check("t4_inv_idx", inv_idx_o,   i);
            check("t4_ready",   upd_ready_o, 0);
            check("t4_count",   count_o,     2);
            step();
        end
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (bp_we_o) got = 1'b1;
            else step();
        end
        check("t4_resume", got, 1);
        check("t4_pc0", bp_pc_o, 32'h400);
        step();
        @(negedge clk);
        check("t4_pc1", bp_pc_o, 32'h404);
        step();

        // Reset in the middle of a sweep
        stall_i = 1'b1;
        drive(1, 32'h500, 1, 32'h5a0);
        step();
        drive(0, 0, 0, 0);
        clear_req_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        repeat (10) step();
        check("t5_idx10", inv_idx_o, 10);
        rst = 1'b1;
        #1;
        check("t5_count",  count_o,      0);
        check("t5_inv_we", inv_we_o,     0);
        check("t5_idx",    inv_idx_o,    0);
        check("t5_busy",   clear_busy_o, 0);
        check("t5_bp_we",  bp_we_o,      0);
        step();
        rst     = 1'b0;
        stall_i = 1'b0;
        step();
        @(negedge clk);
        check("t5_no_write", bp_we_o, 0);
        step();

        // Same PC pushed twice while stalled
        stall_i = 1'b1;
        drive(1, 32'h100, 1, 32'h200);
        step();
        drive(1, 32'h100, 0, 32'h300);
        step();
        drive(0, 0, 0, 0);
        stall_i = 1'b0;
        @(negedge clk);
`ifdef BUPD_COALESCE_EN
        check("t6_count", count_o,    1);
        check("t6_taken", bp_taken_o, 0);
        step();
        @(negedge clk);
        check("t6_single", bp_we_o, 0);
`else
        check("t6_count", count_o,    2);
        check("t6_taken", bp_taken_o, 1);
        step();
        @(negedge clk);
        check("t6_second", bp_taken_o, 0);
`endif
        step();

        // Mixed traffic: stalls, repeated PCs, occasional sweeps
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1) == 1, 32'h600 + 32'(4 * $urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom());
            stall_i     = ($urandom_range(0, 3) == 0);
            clear_req_i = ($urandom_range(0, 99) == 0);
            step();
        end
        drive(0, 0, 0, 0);
        stall_i     = 1'b0;
        clear_req_i = 1'b0;
        repeat (80) step();
        check("end_count", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
